// File: rtl/reg_file_dumper.sv
// reg_file_dumper
//   Walks an inclusive range of register-file indices and presents each
//   (index, value) pair on a valid/ready output port. It keeps a running
//   XOR checksum and a count of the accepted entries. A dump runs
//   IDLE -> READ -> HOLD -> (READ -> HOLD)* -> DONE -> IDLE.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 dump request, sampled only in IDLE
//   first_reg, last_reg   inclusive index range, sampled with start
//   ReadReg               register-file read address (registered)
//   ReadData              combinational register-file read data
//   out_valid/out_ready   output handshake
//   out_reg, out_data     presented entry
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse at the end of a dump
//   range_err             one-cycle pulse on start with first_reg > last_reg
//   checksum, count       XOR and number of accepted entries of the current
//                         or last dump
module reg_file_dumper #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_reg_q, out_reg_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              range_err_q, range_err_d;
  logic              accept;

  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_reg_d   = out_reg_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    range_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Either outcome of a start clears the statistics of the last dump.
          checksum_d = '0;
          count_d    = '0;
          if (first_reg <= last_reg) begin
            cur_d   = first_reg;
            last_d  = last_reg;
            state_d = S_READ;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end

      S_READ: begin
        // ReadReg is cur_q, so ReadData belongs to the current index.
        out_data_d  = ReadData;
        out_reg_d   = cur_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (accept) begin
          checksum_d  = checksum_q ^ out_data_q;
          count_d     = count_q + (ADDR_W + 1)'(1);
          out_valid_d = 1'b0;
          // Test for the end before incrementing so that a range ending at
          // the top index never wraps back to 0.
          if (cur_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_reg_q   <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_reg_q   <= out_reg_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      range_err_q <= range_err_d;
    end
  end

  assign ReadReg   = cur_q;
  assign out_valid = out_valid_q;
  assign out_reg   = out_reg_q;
  assign out_data  = out_data_q;
  assign checksum  = checksum_q;
  assign count     = count_q;
  assign range_err = range_err_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Testbench for reg_file_dumper: a register-file array drives ReadData, and
// every dump is compared against the list of (index, value) pairs, XOR and
// count computed directly from that array and the requested range.
module tb_reg_file_dumper;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] ReadReg;
  logic [DATA_W-1:0] ReadData;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              range_err;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W:0]   count;

  logic [DATA_W-1:0] mem [NREG];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  assign ReadData = mem[ReadReg];

  reg_file_dumper #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .ReadReg   (ReadReg),
    .ReadData  (ReadData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_reg   (out_reg),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .checksum  (checksum),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are observed and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_range_err"}, 64'(range_err), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_checksum"},  64'(checksum),  64'd0);
    chk({tag, "_count"},     64'(count),     64'd0);
    chk({tag, "_out_reg"},   64'(out_reg),   64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_ReadReg"},   64'(ReadReg),   64'd0);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < NREG; i++) mem[i] = DATA_W'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) mem[i] = $urandom;
  endtask

  // Run a complete dump of f..l. Each entry is held for 'stall' cycles before
  // it is accepted; with poke set, start is raised mid-dump and must be ignored.
  task automatic run_dump(input int f, input int l, input int stall, input bit poke);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_cs;
    logic [ADDR_W-1:0] held_reg;
    logic [DATA_W-1:0] held_data;
    int n_exp, n_acc, stall_cnt, last_acc;
    bit seen_done;
    exp_cs = '0;
    for (int i = f; i <= l; i++) begin
      exp_q.push_back(mem[i]);
      exp_cs ^= mem[i];
    end
    n_exp     = l - f + 1;
    n_acc     = 0;
    stall_cnt = 0;
    last_acc  = 0;
    seen_done = 1'b0;
    held_reg  = '0;
    held_data = '0;

    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    start     = 1'b1;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("no_valid_in_read", 64'(out_valid), 64'd0);

    for (int k = 0; k < 600 && !seen_done; k++) begin
      if (out_valid) begin
        if (stall_cnt == 0) begin
          held_reg  = out_reg;
          held_data = out_data;
        end else begin
          chk("stall_out_reg",  64'(out_reg),  64'(held_reg));
          chk("stall_out_data", 64'(out_data), 64'(held_data));
        end
        if (stall_cnt >= stall) begin
          if (n_acc < n_exp) begin
            chk("entry_reg",  64'(out_reg),  64'(f + n_acc));
            chk("entry_data", 64'(out_data), 64'(exp_q[n_acc]));
          end else begin
            chk("extra_entry", 64'(n_acc), 64'(n_exp - 1));
          end
          if (stall == 0 && n_acc > 0) chk("throughput", 64'(cyc - last_acc), 64'd2);
          last_acc  = cyc;
          n_acc++;
          stall_cnt = 0;
          out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        out_ready = 1'b0;
      end
      if (poke && n_acc == 1) begin
        start     = 1'b1;
        first_reg = '0;
        last_reg  = '1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) seen_done = 1'b1;
    end

    start     = 1'b0;
    out_ready = 1'b0;
    chk("done_seen",    64'(seen_done), 64'd1);
    chk("done_latency", 64'(cyc - last_acc), 64'd1);
    chk("n_entries",    64'(n_acc), 64'(n_exp));
    chk("count_done",   64'(count), 64'(n_exp));
    chk("cksum_done",   64'(checksum), 64'(exp_cs));
    chk("busy_in_done", 64'(busy), 64'd1);
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after",     64'(busy), 64'd0);
    chk("count_hold",     64'(count), 64'(n_exp));
    chk("cksum_hold",     64'(checksum), 64'(exp_cs));
  endtask

  initial begin
    bit found, any_bad;
    int f, l;

    // Reset with start and out_ready both high: reset must win.
    rst       = 1'b1;
    start     = 1'b1;
    first_reg = '0;
    last_reg  = '1;
    out_ready = 1'b1;
    fill_identity();
    step();
    step();
    check_reset_outputs("reset");
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    step();
    chk("idle_after_reset", 64'(busy), 64'd0);

    // Range 2..3 with R_i = i, ready held high.
    run_dump(2, 3, 0, 1'b0);
    // Same range with five stalled cycles per entry.
    run_dump(2, 3, 5, 1'b0);
    // Full range, no wrap past the top index.
    run_dump(0, NREG - 1, 0, 1'b0);

    // Inverted range: error pulse, statistics cleared, no output.
    first_reg = 5'd5;
    last_reg  = 5'd4;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("rerr_pulse",    64'(range_err), 64'd1);
    chk("rerr_busy",     64'(busy), 64'd0);
    chk("rerr_count",    64'(count), 64'd0);
    chk("rerr_checksum", 64'(checksum), 64'd0);
    any_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) chk("rerr_one_cycle", 64'(range_err), 64'd1);
      step();
      if (out_valid || done || busy || range_err) any_bad = 1'b1;
    end
    chk("rerr_quiet", 64'(any_bad), 64'd0);
    chk("rerr_count_hold", 64'(count), 64'd0);

    // start pulsed while busy must be ignored.
    run_dump(2, 3, 1, 1'b1);

    // Reset while an entry is held, with out_ready high on the same edge.
    first_reg = 5'd2;
    last_reg  = 5'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (out_valid) found = 1'b1;
      else step();
    end
    chk("hold_reached", 64'(found), 64'd1);
    out_ready = 1'b1;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_reset_outputs("mid_reset");
    any_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done || busy || out_valid) any_bad = 1'b1;
    end
    chk("mid_reset_quiet", 64'(any_bad), 64'd0);
    run_dump(2, 3, 0, 1'b0);

    // Single entry at the top index.
    fill_random();
    run_dump(NREG - 1, NREG - 1, 2, 1'b0);

    // Random contents, ranges and stall lengths.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      f = int'($urandom_range(NREG - 1, 0));
      l = int'($urandom_range(NREG - 1, f));
      run_dump(f, l, int'($urandom_range(3, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
